iddmm_arbiter: RTL and testbench
================================

IDDMM_ARBITER -- requirements
Module: iddmm_arbiter

Interface
REQ-001 Parameter K, default 128, operand word width in bits.
REQ-002 Parameter N, default 32, number of words per operand; AW = $clog2(N).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 r0_lock_req / r1_lock_req  input  1  level request for exclusive ownership of the IDDMM core; held for the whole owned session.
REQ-006 r0_own / r1_own  output  1  registered ownership indication; at most one high.
REQ-007 rX_wr_ena  input  3  per-requester write enables: x, y, m/m1.
REQ-008 rX_wr_addr  input  AW  per-requester word address.
REQ-009 rX_wr_x, rX_wr_y, rX_wr_m, rX_wr_m1  input  K each  per-requester operand words, low word first.
REQ-010 rX_task_req  input  1  per-requester task request, forwarded to core when owner.
REQ-011 rX_task_grant, rX_task_end  output  1 each  core grant/end pulses routed to owner only.
REQ-012 rX_task_res  output  K  core result word routed to owner only.
REQ-013 core_wr_ena 3, core_wr_addr AW, core_wr_x/y/m/m1 K each, core_task_req 1  outputs  muxed core drive.
REQ-014 core_task_grant 1, core_task_end 1, core_task_res K  inputs  from IDDMM core.
REQ-015 core_busy  output  1  high from accepted core grant until core task_end.

Function
REQ-016 FSM states: IDLE, OWN0, OWN1, DRAIN0, DRAIN1; state, owner flags, busy and rr pointer are registers.
REQ-017 IDLE: if exactly one lock_req high, go to matching OWNx next cycle; rX_own high that cycle (1-cycle grant latency).
REQ-018 IDLE with both lock_req high: grant the requester not equal to rr pointer; rr pointer := granted index on grant.
REQ-019 OWNx: owner's wr_ena, wr_addr, wr_* and task_req drive core_* combinationally; non-owner inputs ignored.
REQ-020 OWNx: core_task_grant, core_task_end, core_task_res drive owner rX_* outputs; non-owner outputs held 0.
REQ-021 busy set on cycle after core_task_grant=1 in OWNx; cleared on cycle after core_task_end=1; end wins if both same cycle.
REQ-022 OWNx, lock_req dropped, busy=0 and no core_task_end this cycle: go IDLE; rX_own low next cycle.
REQ-023 OWNx, lock_req dropped while busy=1: go DRAINx; rX_own stays high; core_wr_ena and core_task_req forced 0.
REQ-024 DRAINx: grant/end/res still routed to owner; on core_task_end go IDLE, busy cleared.
REQ-025 Minimum one IDLE cycle between any release and next grant, including same requester re-acquiring.
REQ-026 IDLE/no owner: all core_* outputs 0; all rX_task_grant/end/res 0.
REQ-027 lock_req re-asserted in DRAINx is ignored until IDLE; arbitration then proceeds per REQ-017/018.
REQ-028 core_busy equals busy register.

Reset
REQ-029 rst=1 at a clock edge: state IDLE, r0_own=r1_own=0, busy=0, rr pointer=1 (r0 wins first tie), all core_* and rX_* outputs 0 next cycle.
REQ-030 Reset mid-session, including DRAIN, abandons ownership immediately; in-flight core result is not routed.

Verification
REQ-031 After reset, r0_lock_req=r1_lock_req=1 same cycle -> r0_own=1 next cycle; r0 releases -> one IDLE cycle -> r1_own=1.
REQ-032 r1 owns, r1_wr_ena=3'b001, addr=5, x=0xA5 -> core_wr_ena=001, core_wr_addr=5, core_wr_x=0xA5 same cycle; r0 inputs have no effect.
REQ-033 r0 owns, core_task_grant then core_task_end with core_task_res=0x1234 -> r0_task_end=1, r0_task_res=0x1234; r1 outputs 0; core_busy high between.
REQ-034 r0 drops lock_req while busy -> DRAIN0, core_task_req=0, r0_own=1 until core_task_end, then IDLE; pending r1 granted 2 cycles after end.
REQ-035 rst=1 during OWN1 with busy=1 -> next cycle r1_own=0, core_busy=0, core_* all 0; first tie afterwards granted to r0.
REQ-036 Both requesters continuously re-request for 4 sessions -> grants alternate r0, r1, r0, r1, never both own high.

Source files
------------

// File: rtl/iddmm_arbiter.sv
// iddmm_arbiter: grants one of two requesters exclusive ownership of a shared IDDMM core
module iddmm_arbiter #(
  parameter int K = 128,
  parameter int N = 32,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_lock_req,
  input  logic          r1_lock_req,
  output logic          r0_own,
  output logic          r1_own,
  input  logic [2:0]    r0_wr_ena,
  input  logic [AW-1:0] r0_wr_addr,
  input  logic [K-1:0]  r0_wr_x,
  input  logic [K-1:0]  r0_wr_y,
  input  logic [K-1:0]  r0_wr_m,
  input  logic [K-1:0]  r0_wr_m1,
  input  logic          r0_task_req,
  output logic          r0_task_grant,
  output logic          r0_task_end,
  output logic [K-1:0]  r0_task_res,
  input  logic [2:0]    r1_wr_ena,
  input  logic [AW-1:0] r1_wr_addr,
  input  logic [K-1:0]  r1_wr_x,
  input  logic [K-1:0]  r1_wr_y,
  input  logic [K-1:0]  r1_wr_m,
  input  logic [K-1:0]  r1_wr_m1,
  input  logic          r1_task_req,
  output logic          r1_task_grant,
  output logic          r1_task_end,
  output logic [K-1:0]  r1_task_res,
  output logic [2:0]    core_wr_ena,
  output logic [AW-1:0] core_wr_addr,
  output logic [K-1:0]  core_wr_x,
  output logic [K-1:0]  core_wr_y,
  output logic [K-1:0]  core_wr_m,
  output logic [K-1:0]  core_wr_m1,
  output logic          core_task_req,
  input  logic          core_task_grant,
  input  logic          core_task_end,
  input  logic [K-1:0]  core_task_res,
  output logic          core_busy
);
  typedef enum logic [2:0] {IDLE, OWN0, OWN1, DRAIN0, DRAIN1} state_t;
  state_t state, state_nxt;
  logic busy, busy_nxt, rr, rr_nxt, lock, gnt_sel, active, busy_run;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      rr     <= 1'b1;
      r0_own <= 1'b0;
      r1_own <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= busy_nxt;
      rr     <= rr_nxt;
      r0_own <= state_nxt == OWN0 || state_nxt == DRAIN0;
      r1_own <= state_nxt == OWN1 || state_nxt == DRAIN1;
    end
  end
  always_comb begin
    lock      = r1_own ? r1_lock_req : r0_lock_req;
    gnt_sel   = (r0_lock_req && r1_lock_req) ? ~rr : r1_lock_req;
    busy_run  = !core_task_end && (busy || core_task_grant);
    state_nxt = state;
    rr_nxt    = rr;
    case (state)
      IDLE: if (r0_lock_req || r1_lock_req) begin
        state_nxt = gnt_sel ? OWN1 : OWN0;
        rr_nxt    = gnt_sel;
      end
      // an end pulse without a tracked task delays release by one cycle
      OWN0, OWN1: if (!lock) state_nxt = busy_run ? (r1_own ? DRAIN1 : DRAIN0) : core_task_end ? state : IDLE;
      default: if (core_task_end) state_nxt = IDLE;
    endcase
    busy_nxt = state != IDLE && state_nxt != IDLE && busy_run;
  end
  assign active        = state == OWN0 || state == OWN1;
  assign core_wr_ena   = active ? (r1_own ? r1_wr_ena : r0_wr_ena) : 3'b0;
  assign core_task_req = active && (r1_own ? r1_task_req : r0_task_req);
  assign core_wr_addr  = r1_own ? r1_wr_addr : r0_own ? r0_wr_addr : '0;
  assign core_wr_x     = r1_own ? r1_wr_x : r0_own ? r0_wr_x : '0;
  assign core_wr_y     = r1_own ? r1_wr_y : r0_own ? r0_wr_y : '0;
  assign core_wr_m     = r1_own ? r1_wr_m : r0_own ? r0_wr_m : '0;
  assign core_wr_m1    = r1_own ? r1_wr_m1 : r0_own ? r0_wr_m1 : '0;
  assign core_busy     = busy;
  assign r0_task_grant = r0_own && core_task_grant;
  assign r0_task_end   = r0_own && core_task_end;
  assign r0_task_res   = r0_own ? core_task_res : '0;
  assign r1_task_grant = r1_own && core_task_grant;
  assign r1_task_end   = r1_own && core_task_end;
  assign r1_task_res   = r1_own ? core_task_res : '0;
endmodule

// File: tb/tb_iddmm_arbiter.sv
// tb_iddmm_arbiter: directed vectors, corner sequences and random traffic against an ownership model
module tb_iddmm_arbiter;
  localparam int K = 16;
  localparam int N = 8;
  localparam int AW = 3;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [1:0] lock, treq, own, tgnt, tend;
  logic [2:0] ena [2];
  logic [AW-1:0] addr [2];
  logic [K-1:0] wx [2], wy [2], wm [2], wm1 [2], tres [2];
  logic [2:0] c_ena;
  logic [AW-1:0] c_addr;
  logic [K-1:0] c_x, c_y, c_m, c_m1, c_res;
  logic c_treq, c_gnt, c_end, c_busy;
  int checks = 0, errors = 0;
  int m_owner, m_last;
  bit m_drain, m_busy;

  iddmm_arbiter #(.K(K), .N(N)) dut (
    .clk(clk), .rst(rst),
    .r0_lock_req(lock[0]), .r1_lock_req(lock[1]), .r0_own(own[0]), .r1_own(own[1]),
    .r0_wr_ena(ena[0]), .r0_wr_addr(addr[0]), .r0_wr_x(wx[0]), .r0_wr_y(wy[0]), .r0_wr_m(wm[0]), .r0_wr_m1(wm1[0]),
    .r0_task_req(treq[0]), .r0_task_grant(tgnt[0]), .r0_task_end(tend[0]), .r0_task_res(tres[0]),
    .r1_wr_ena(ena[1]), .r1_wr_addr(addr[1]), .r1_wr_x(wx[1]), .r1_wr_y(wy[1]), .r1_wr_m(wm[1]), .r1_wr_m1(wm1[1]),
    .r1_task_req(treq[1]), .r1_task_grant(tgnt[1]), .r1_task_end(tend[1]), .r1_task_res(tres[1]),
    .core_wr_ena(c_ena), .core_wr_addr(c_addr), .core_wr_x(c_x), .core_wr_y(c_y), .core_wr_m(c_m), .core_wr_m1(c_m1),
    .core_task_req(c_treq), .core_task_grant(c_gnt), .core_task_end(c_end), .core_task_res(c_res), .core_busy(c_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    int i = m_owner < 0 ? 0 : m_owner;
    bit o = m_owner >= 0;
    bit act = o && !m_drain;
    chk("m_r0_own", own[0], m_owner == 0);
    chk("m_r1_own", own[1], m_owner == 1);
    chk("m_busy", c_busy, m_busy);
    chk("m_core_wr_ena", c_ena, act ? ena[i] : 3'b0);
    chk("m_core_task_req", c_treq, act && treq[i]);
    chk("m_core_wr_addr", c_addr, o ? addr[i] : '0);
    chk("m_core_wr_x", c_x, o ? wx[i] : '0);
    chk("m_core_wr_y", c_y, o ? wy[i] : '0);
    chk("m_core_wr_m", c_m, o ? wm[i] : '0);
    chk("m_core_wr_m1", c_m1, o ? wm1[i] : '0);
    for (int r = 0; r < 2; r++) begin
      chk("m_task_grant", tgnt[r], m_owner == r && c_gnt);
      chk("m_task_end", tend[r], m_owner == r && c_end);
      chk("m_task_res", tres[r], m_owner == r ? c_res : '0);
    end
  endtask

  task automatic model_step();
    bit nb;
    if (rst) begin
      m_owner = -1; m_drain = 0; m_busy = 0; m_last = 1;
    end else if (m_owner < 0) begin
      if (lock == 2'b11) m_owner = 1 - m_last;
      else if (lock[0]) m_owner = 0;
      else if (lock[1]) m_owner = 1;
      if (m_owner >= 0) m_last = m_owner;
      m_busy = 0;
    end else begin
      nb = !c_end && (m_busy || c_gnt);
      if (m_drain) begin
        if (c_end) begin m_owner = -1; m_drain = 0; m_busy = 0; end
      end else if (!lock[m_owner]) begin
        if (nb) m_drain = 1;
        else if (!c_end) m_owner = -1;
        m_busy = nb;
      end else m_busy = nb;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic [2:0] ena0; logic [AW-1:0] addr0; logic [K-1:0] x0;
    logic [2:0] ena1; logic [AW-1:0] addr1; logic [K-1:0] x1;
    logic [2:0] e_ena; logic [AW-1:0] e_addr; logic [K-1:0] e_x;
  } vec_t;
  vec_t tbl [4];

  initial begin
    tbl[0] = '{3'b111, 3, 16'hFFFF, 3'b001, 5, 16'h00A5, 3'b001, 5, 16'h00A5};
    tbl[1] = '{3'b010, 1, 16'h1111, 3'b100, 7, 16'hBEEF, 3'b100, 7, 16'hBEEF};
    tbl[2] = '{3'b000, 2, 16'h2222, 3'b000, 0, 16'h0000, 3'b000, 0, 16'h0000};
    tbl[3] = '{3'b101, 6, 16'h3333, 3'b110, 2, 16'h0F0F, 3'b110, 2, 16'h0F0F};
    rst = 1; lock = 0; treq = 0; c_gnt = 0; c_end = 0; c_res = 0;
    for (int r = 0; r < 2; r++) begin
      ena[r] = 0; addr[r] = 0; wx[r] = 0; wy[r] = 0; wm[r] = 0; wm1[r] = 0;
    end
    m_owner = -1; m_drain = 0; m_busy = 0; m_last = 1;
    cyc(); cyc();
    chk("reset_own", {own, c_busy, c_treq, c_ena}, 0);
    rst = 0;
    // tie after reset goes to r0, release, one idle cycle, then r1
    lock = 2'b11; cyc();
    chk("tie_r0_own", own, 2'b01);
    lock = 2'b10; cyc();
    chk("release_idle", own, 2'b00);
    cyc();
    chk("r1_after_idle", own, 2'b10);
    for (int v = 0; v < 4; v++) begin
      ena[0] = tbl[v].ena0; addr[0] = tbl[v].addr0; wx[0] = tbl[v].x0;
      ena[1] = tbl[v].ena1; addr[1] = tbl[v].addr1; wx[1] = tbl[v].x1;
      #1;
      chk("tbl_ena", c_ena, tbl[v].e_ena);
      chk("tbl_addr", c_addr, tbl[v].e_addr);
      chk("tbl_x", c_x, tbl[v].e_x);
      cyc();
    end
    ena[0] = 0; ena[1] = 0;
    lock = 2'b00; cyc();
    // r0 task with result routed only to r0
    lock = 2'b01; cyc();
    chk("r0_own_task", own, 2'b01);
    treq[0] = 1; c_gnt = 1; #1;
    chk("r0_grant", {tgnt, c_treq}, 3'b011);
    cyc();
    c_gnt = 0; treq[0] = 0;
    chk("busy_set", c_busy, 1);
    cyc();
    chk("busy_hold", c_busy, 1);
    c_end = 1; c_res = 16'h1234; #1;
    chk("r0_end", tend, 2'b01);
    chk("r0_res", tres[0], 16'h1234);
    chk("r1_res", tres[1], 0);
    cyc();
    c_end = 0; c_res = 0;
    chk("busy_clr", c_busy, 0);
    // drop while busy drains, r1 granted two cycles after end
    treq[0] = 1; c_gnt = 1; cyc();
    c_gnt = 0;
    lock = 2'b10; ena[0] = 3'b111; cyc();
    chk("drain_gate", {own, c_treq, c_ena}, {2'b01, 1'b0, 3'b000});
    cyc();
    chk("drain_own", own, 2'b01);
    c_end = 1; c_res = 16'h0005; #1;
    chk("drain_end", tend, 2'b01);
    cyc();
    c_end = 0; c_res = 0; treq[0] = 0; ena[0] = 0;
    chk("drain_idle", own, 2'b00);
    cyc();
    chk("drain_r1_grant", own, 2'b10);
    // reset mid-task abandons ownership
    treq[1] = 1; c_gnt = 1; cyc();
    c_gnt = 0;
    chk("r1_busy", c_busy, 1);
    rst = 1; ena[1] = 3'b011; addr[1] = 4; c_res = 16'hABCD; cyc();
    chk("rst_mid", {own, c_busy, c_treq, c_ena, c_addr}, 0);
    chk("rst_res", tres[1], 0);
    rst = 0; treq[1] = 0; ena[1] = 0; addr[1] = 0; c_res = 0;
    lock = 2'b11; cyc();
    chk("rst_tie_r0", own, 2'b01);
    // continuous re-requesting alternates ownership
    for (int s = 0; s < 4; s++) begin
      chk("alt_own", own, s % 2 == 0 ? 2'b01 : 2'b10);
      cyc(); cyc();
      lock[s % 2] = 0; cyc();
      chk("alt_gap", own, 2'b00);
      lock[s % 2] = 1; cyc();
    end
    lock = 0; cyc(); cyc();
    for (int c = 0; c < 800; c++) begin
      rst = $urandom_range(0, 120) == 0;
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 7) == 0) lock[r] = ~lock[r];
        ena[r] = 3'($urandom); addr[r] = AW'($urandom); treq[r] = 1'($urandom);
        wx[r] = K'($urandom); wy[r] = K'($urandom); wm[r] = K'($urandom); wm1[r] = K'($urandom);
      end
      c_res = K'($urandom); c_gnt = 0; c_end = 0;
      if (m_owner < 0) begin
        c_gnt = 1'($urandom); c_end = 1'($urandom);
      end else if (m_drain || lock[m_owner]) begin
        if (m_busy) c_end = $urandom_range(0, 3) == 0;
        else c_gnt = $urandom_range(0, 2) == 0;
      end
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
